// File: rtl/rat_int_ctrl.sv
// Interrupt controller for the RAT MCU: edge-detected requests, per-source mask, fixed-priority arbitration.
// Latency: IRQ rise -> pend set at the next edge -> INT_CU high one edge later (2 clocks); RD_DATA is combinational.
// Backpressure: none; a new interrupt is held off until INT_DONE, and events keep accumulating in pend meanwhile.
//
// Ports:
//   CLK, RESET          system clock, asynchronous active-high reset
//   IRQ[NUM_SRC]        request lines; a 0->1 transition is one event
//   IO_STRB, PORT_ID,   OUT-port write strobe, address and data from the MCU
//   OUT_PORT
//   INT_ACK, INT_DONE   control-unit pulses: interrupt entered / RETIE-RETID executed
//   INT_CU              registered interrupt request to the control unit
//   INT_ID              index of the source in service, zero-extended
//   RD_DATA             IN-port read data, combinational on PORT_ID

module rat_int_ctrl #(
  parameter int         NUM_SRC   = 4,
  parameter logic [7:0] MASK_PORT = 8'h40,
  parameter logic [7:0] ID_PORT   = 8'h41,
  parameter logic [7:0] PEND_PORT = 8'h42
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_SRC-1:0] IRQ,
  input  logic               IO_STRB,
  input  logic [7:0]         PORT_ID,
  input  logic [7:0]         OUT_PORT,
  input  logic               INT_ACK,
  input  logic               INT_DONE,
  output logic               INT_CU,
  output logic [7:0]         INT_ID,
  output logic [7:0]         RD_DATA
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t             state;
  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] mask;

  logic [NUM_SRC-1:0] irq_rise;
  logic [NUM_SRC-1:0] eff;
  logic [NUM_SRC-1:0] w1c_clr;
  logic [NUM_SRC-1:0] ack_clr;
  logic [NUM_SRC-1:0] pend_nxt;
  logic               mask_wr;
  logic               pend_wr;
  logic               win_vld;
  logic [2:0]         win_idx;
  logic               ack_take;

  // Only the low NUM_SRC bits of the write data are architectural.
  logic               unused_out_port;
  assign unused_out_port = ^OUT_PORT;

  // ------------------------------------------------------------------
  // Request path
  // ------------------------------------------------------------------

  // irq_q resets to 0, so a line already high when RESET drops is an event.
  assign irq_rise = IRQ & ~irq_q;
  assign eff      = pend & mask;

  assign mask_wr  = IO_STRB && (PORT_ID == MASK_PORT);
  assign pend_wr  = IO_STRB && (PORT_ID == PEND_PORT);
  assign w1c_clr  = pend_wr ? OUT_PORT[NUM_SRC-1:0] : '0;

  // Fixed priority: the lowest index with an effective request wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eff[i]) begin
        win_vld = 1'b1;
        win_idx = 3'(i);
      end
    end
  end

  // An acknowledge only counts in REQ with a live winner; if eff has just
  // dropped to zero the FSM is already on its way back to IDLE.
  assign ack_take = (state == ST_REQ) && INT_ACK && win_vld;

  // eff & -eff isolates the lowest set bit, i.e. the winner as a one-hot.
  assign ack_clr  = ack_take ? (eff & (~eff + NUM_SRC'(1))) : '0;

  // Clears are applied first so a same-cycle rising edge keeps its bit.
  assign pend_nxt = (pend & ~(w1c_clr | ack_clr)) | irq_rise;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      irq_q <= '0;
      pend  <= '0;
      mask  <= '0;
    end else begin
      irq_q <= IRQ;
      pend  <= pend_nxt;
      if (mask_wr) begin
        mask <= OUT_PORT[NUM_SRC-1:0];
      end
    end
  end

  // ------------------------------------------------------------------
  // Request / service sequencer
  // ------------------------------------------------------------------

  // INT_CU is updated alongside state so it is high exactly in REQ,
  // straight from a flop. Arbitration uses the current mask, so a mask
  // write in the acknowledge cycle does not affect the winner.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= ST_IDLE;
      INT_CU <= 1'b0;
      INT_ID <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_vld) begin
            state  <= ST_REQ;
            INT_CU <= 1'b1;
          end
        end

        ST_REQ: begin
          if (!win_vld) begin
            // Request withdrawn by a mask write or W1C before acknowledge.
            state  <= ST_IDLE;
            INT_CU <= 1'b0;
          end else if (INT_ACK) begin
            state  <= ST_SERVICE;
            INT_CU <= 1'b0;
            INT_ID <= {5'd0, win_idx};
          end
        end

        ST_SERVICE: begin
          // Always pass through IDLE; any leftover request re-enters REQ
          // one cycle later, so nesting is impossible.
          if (INT_DONE) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state  <= ST_IDLE;
          INT_CU <= 1'b0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // IN-port read mux
  // ------------------------------------------------------------------

  always_comb begin
    RD_DATA = 8'h00;
    case (PORT_ID)
      MASK_PORT: RD_DATA[NUM_SRC-1:0] = mask;
      ID_PORT:   RD_DATA              = INT_ID;
      PEND_PORT: RD_DATA[NUM_SRC-1:0] = pend;
      default:   RD_DATA              = 8'h00;
    endcase
  end

  // ------------------------------------------------------------------
  // Structural invariants
  // ------------------------------------------------------------------

  a_cu_is_req: assert property (@(posedge CLK) disable iff (RESET)
    INT_CU == (state == ST_REQ));

  a_state_legal: assert property (@(posedge CLK) disable iff (RESET)
    state != 2'd3);

  a_ack_onehot: assert property (@(posedge CLK) disable iff (RESET)
    $onehot0(ack_clr));

endmodule

// File: tb/tb_rat_int_ctrl.sv
// Bench for rat_int_ctrl: directed test-plan sequences followed by random
// stimulus, scored against a behavioural model through an expectation queue.

module tb_rat_int_ctrl;

  localparam int         NUM_SRC   = 4;
  localparam logic [7:0] MASK_PORT = 8'h40;
  localparam logic [7:0] ID_PORT   = 8'h41;
  localparam logic [7:0] PEND_PORT = 8'h42;
  localparam logic [7:0] LOW       = 8'((1 << NUM_SRC) - 1);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NUM_SRC-1:0] irq = '0;
  logic               io_strb = 1'b0;
  logic [7:0]         port_id = 8'h00;
  logic [7:0]         out_port = 8'h00;
  logic               int_ack = 1'b0;
  logic               int_done = 1'b0;
  logic               int_cu;
  logic [7:0]         int_id;
  logic [7:0]         rd_data;

  rat_int_ctrl #(
    .NUM_SRC  (NUM_SRC),
    .MASK_PORT(MASK_PORT),
    .ID_PORT  (ID_PORT),
    .PEND_PORT(PEND_PORT)
  ) dut (
    .CLK     (clk),
    .RESET   (rst),
    .IRQ     (irq),
    .IO_STRB (io_strb),
    .PORT_ID (port_id),
    .OUT_PORT(out_port),
    .INT_ACK (int_ack),
    .INT_DONE(int_done),
    .INT_CU  (int_cu),
    .INT_ID  (int_id),
    .RD_DATA (rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       int_cu;
    logic [7:0] int_id;
    logic [7:0] rd;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Behavioural model: sets of pending/enabled sources plus two flags
  // saying whether the CPU is being asked to interrupt or is servicing.
  logic [7:0] m_pend, m_mask, m_prev, m_id;
  bit         m_asking, m_servicing;

  task automatic model_reset();
    m_pend = 8'h00; m_mask = 8'h00; m_prev = 8'h00; m_id = 8'h00;
    m_asking = 1'b0; m_servicing = 1'b0;
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] p);
    if (p == MASK_PORT) return m_mask;
    if (p == ID_PORT)   return m_id;
    if (p == PEND_PORT) return m_pend;
    return 8'h00;
  endfunction

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic model_edge();
    logic [7:0] now, rises, enabled, clr;
    int         first;
    if (rst) begin
      model_reset();
      return;
    end
    now     = 8'(irq);
    rises   = now & ~m_prev;
    enabled = m_pend & m_mask;
    first   = -1;
    for (int i = NUM_SRC - 1; i >= 0; i--) if (enabled[i]) first = i;
    clr = 8'h00;
    if (m_servicing) begin
      if (int_done) m_servicing = 1'b0;
    end else if (m_asking) begin
      if (enabled == 8'h00) m_asking = 1'b0;
      else if (int_ack) begin
        m_asking    = 1'b0;
        m_servicing = 1'b1;
        m_id        = 8'(first);
        clr[first]  = 1'b1;
      end
    end else if (enabled != 8'h00) begin
      m_asking = 1'b1;
    end
    if (io_strb && port_id == PEND_PORT) clr = clr | out_port;
    if (io_strb && port_id == MASK_PORT) m_mask = out_port & LOW;
    m_pend = ((m_pend & ~clr) | rises) & LOW;
    m_prev = now;
  endtask

  // One clock: record what the DUT must show before this edge, take the
  // edge, advance the model, then drop the one-cycle pulses.
  task automatic step();
    exp_t e;
    if (rst) model_reset();
    e.int_cu = m_asking;
    e.int_id = m_id;
    e.rd     = model_read(port_id);
    e.cyc    = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    model_edge();
    io_strb  = 1'b0;
    int_ack  = 1'b0;
    int_done = 1'b0;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %02h expected %02h", name, cyc, act, req);
    end
  endtask

  task automatic wr(input logic [7:0] p, input logic [7:0] d);
    io_strb = 1'b1; port_id = p; out_port = d;
  endtask

  // Monitor: compares the DUT against the oldest expectation each negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp += 3;
        if (int_cu !== e.int_cu) begin
          n_bad++;
          $display("FAIL int_cu cycle %0d: got %b expected %b", e.cyc, int_cu, e.int_cu);
        end
        if (int_id !== e.int_id) begin
          n_bad++;
          $display("FAIL int_id cycle %0d: got %02h expected %02h", e.cyc, int_id, e.int_id);
        end
        if (rd_data !== e.rd) begin
          n_bad++;
          $display("FAIL rd_data cycle %0d port %02h: got %02h expected %02h",
                   e.cyc, port_id, rd_data, e.rd);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    // Reset held for two cycles.
    rst = 1'b1; step(); step();
    chk("reset_int_cu", 8'(int_cu), 8'h00);
    chk("reset_int_id", int_id, 8'h00);
    rst = 1'b0;

    // Single source: mask 0F, pulse IRQ[2].
    wr(MASK_PORT, 8'h0F); step();
    port_id = PEND_PORT;
    irq = 4'b0100; step();
    irq = 4'b0000; step();
    chk("irq2_latency", 8'(int_cu), 8'h01);
    int_ack = 1'b1; step();
    chk("ack_cu_low", 8'(int_cu), 8'h00);
    chk("ack_id2", int_id, 8'h02);
    chk("ack_pend_clr", rd_data, 8'h00);
    int_done = 1'b1; step();

    // Two simultaneous sources: priority then re-request after DONE.
    irq = 4'b1010; step();
    irq = 4'b0000; step();
    int_ack = 1'b1; step();
    chk("prio_id1", int_id, 8'h01);
    int_done = 1'b1; step();
    step();
    chk("rereq_cu", 8'(int_cu), 8'h01);
    int_ack = 1'b1; step();
    chk("second_id3", int_id, 8'h03);
    int_done = 1'b1; step();

    // Masked source stays pending until unmasked.
    wr(MASK_PORT, 8'h00); step();
    port_id = PEND_PORT;
    irq = 4'b0001; step();
    irq = 4'b0000; step(); step();
    chk("masked_cu", 8'(int_cu), 8'h00);
    chk("masked_pend", rd_data, 8'h01);
    wr(MASK_PORT, 8'h01); step();
    port_id = PEND_PORT; step();
    chk("unmask_cu", 8'(int_cu), 8'h01);

    // W1C in REQ withdraws the request; a late ACK is ignored.
    wr(PEND_PORT, 8'h01); step();
    step();
    chk("w1c_cu_drop", 8'(int_cu), 8'h00);
    int_ack = 1'b1; step();
    chk("late_ack_cu", 8'(int_cu), 8'h00);
    chk("late_ack_id", int_id, 8'h03);

    // Reset in SERVICE with a fresh event pending.
    irq = 4'b0001; step();
    irq = 4'b0000; step();
    int_ack = 1'b1; step();
    irq = 4'b0001; step();
    chk("svc_pend_acc", rd_data, 8'h01);
    rst = 1'b1; step();
    chk("rst_svc_cu", 8'(int_cu), 8'h00);
    chk("rst_svc_id", int_id, 8'h00);
    chk("rst_svc_pend", rd_data, 8'h00);
    port_id = MASK_PORT; #1;
    chk("rst_svc_mask", rd_data, 8'h00);
    port_id = PEND_PORT;
    // IRQ[0] still high at release counts as an edge.
    rst = 1'b0; step();
    chk("rst_edge_hist", rd_data, 8'h01);

    // Set beats W1C on the same bit.
    irq = 4'b0000; wr(PEND_PORT, 8'hFF); step();
    irq = 4'b0100; wr(PEND_PORT, 8'h04); step();
    chk("set_beats_w1c", rd_data, 8'h04);
    irq = 4'b0000; wr(PEND_PORT, 8'h0F); step();

    // Random phase.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int b = 0; b < NUM_SRC; b++)
        if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
      io_strb = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 4))
        0:       port_id = MASK_PORT;
        1:       port_id = ID_PORT;
        2, 3:    port_id = PEND_PORT;
        default: port_id = 8'($urandom);
      endcase
      out_port = 8'($urandom);
      int_ack  = m_asking ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      int_done = ($urandom_range(0, 4) == 0);
      step();
    end
    rst = 1'b0;
    step(); step();

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rat_int_ctrl.md
# rat_int_ctrl

Interrupt controller for the RAT MCU. It collects up to eight interrupt request lines and keeps a pending bit and a mask bit for each. It drives the single `INT_CU` input of the control unit, and arbitrates by fixed priority. It records which source is being serviced and sequences request, acknowledge and return through a three-state machine, so a new interrupt cannot nest on one in service. The MCU configures and inspects it through IN/OUT port accesses on the existing `PORT_ID`/`IO_STRB` bus.

## Interface
- `NUM_SRC`, 4: number of request lines, 1..8; index 0 has highest priority.
- `MASK_PORT`, 8'h40: port ID of the mask register (read/write).
- `ID_PORT`, 8'h41: port ID of the serviced-source ID (read only).
- `PEND_PORT`, 8'h42: port ID of the pending register (read; write-1-to-clear).

- `CLK`  in  1  system clock; all state changes on its rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `IRQ`  in  NUM_SRC  request lines, synchronous to `CLK`; a rising edge is an event.
- `IO_STRB`  in  1  one-cycle write strobe from the control unit.
- `PORT_ID`  in  8  port address for writes and reads.
- `OUT_PORT`  in  8  write data from the MCU.
- `INT_ACK`  in  1  one-cycle pulse from the control unit when it enters the interrupt state.
- `INT_DONE`  in  1  one-cycle pulse when RETIE/RETID executes.
- `INT_CU`  out  1  registered interrupt request to the control unit.
- `INT_ID`  out  8  index of the source being serviced, zero-extended.
- `RD_DATA`  out  8  combinational read data for the IN-port mux.

## Operation
- Edge detect: a registered copy of `IRQ` is kept. When `IRQ[i]` is 1 and its previous value was 0, `pend[i]` is set.
- A request that stays high sets `pend[i]` only once.
- Effective requests: `eff = pend & mask`, using only the low `NUM_SRC` bits.
- Winner: the lowest index with `eff` set. It is computed combinationally at the time of acknowledge.
- Register writes, when `IO_STRB`=1:
  - `PORT_ID`=`MASK_PORT`: `mask <= OUT_PORT[NUM_SRC-1:0]`.
  - `PORT_ID`=`PEND_PORT`: clears every `pend` bit where `OUT_PORT` holds 1.
- Register reads, combinational on `PORT_ID`:
  - `MASK_PORT` returns the mask, zero-extended.
  - `ID_PORT` returns `INT_ID`.
  - `PEND_PORT` returns the pending bits, zero-extended.
  - Any other port ID returns 8'h00.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE → REQ when `eff` is nonzero.
  - REQ → SERVICE on `INT_ACK`. In the same edge, `INT_ID` <= winner and `pend[winner]` is cleared.
  - REQ → IDLE when `eff` becomes 0 (masked off or cleared by W1C) before `INT_ACK`.
  - SERVICE → IDLE on `INT_DONE`. If `eff` is still nonzero, the FSM re-enters REQ one cycle later.
- `INT_CU` = 1 exactly when the state is REQ. It is a registered output.
- Ignored events:
  - `INT_ACK` in IDLE or SERVICE.
  - `INT_DONE` in IDLE or REQ.
- Simultaneous events:
  - A new edge on bit i and a W1C or acknowledge clear of bit i in the same cycle: the set wins and the bit stays pending.
  - Edges on several bits in one cycle: all of them are set.
  - A mask write in the same cycle as `INT_ACK`: arbitration uses the old mask.
- Events still accumulate in `pend` during SERVICE and are serviced after `INT_DONE`.
- Reset state:
  - state IDLE, `pend`=0, `mask`=0, edge history=0, `INT_CU`=0, `INT_ID`=0.
  - `RD_DATA` follows from the reset registers.
- Reset asserted mid-service: everything returns to the reset state immediately, with no pending bit retained.
- Reset-state edge history: if `IRQ[i]` is already 1 when `RESET` deasserts, that counts as an edge and `pend[i]` is set on the first clock.

## Timing
- Edge detected at edge N: `pend` is set at N, `INT_CU` goes high at N+1. Latency from `IRQ` high to `INT_CU` high is 2 clocks, given mask=1 and state IDLE.
- `INT_ACK` sampled at edge M: `INT_CU` goes low, `INT_ID` is valid and the pending bit is cleared, all at M.
- `INT_DONE` at edge K with other requests still pending: `INT_CU` goes high again at K+1.
- Mask cleared at edge M while in REQ: `INT_CU` goes low at M+1.
- `RD_DATA` has zero latency from `PORT_ID`; it reflects register values after the most recent edge.

## Test plan
- Reset with `IRQ`=0, write mask 8'h0F, pulse `IRQ[2]` → `INT_CU` high 2 clocks later; `INT_ACK` → `INT_CU` low, `INT_ID`=8'h02, `PEND_PORT` read = 8'h00.
- `IRQ[1]` and `IRQ[3]` rise in the same cycle → `INT_ACK` gives `INT_ID`=1; `INT_DONE` → `INT_CU` reasserts; second `INT_ACK` gives `INT_ID`=3.
- mask=8'h00, pulse `IRQ[0]` → `INT_CU` stays 0 and pending reads 8'h01; write mask 8'h01 → `INT_CU` high 2 clocks after the write.
- In REQ, W1C 8'h01 to `PEND_PORT` → FSM returns to IDLE and `INT_CU` drops next cycle; `INT_ACK` issued afterwards is ignored.
- In SERVICE, pulse `IRQ[0]` and assert `RESET` for 1 cycle → `INT_CU`=0, `INT_ID`=0, pending=0, mask=0.
- Edge on bit 2 in the same cycle as W1C 8'h04 → pending still reads 8'h04.
